// File: rtl/ext_bus_master.sv
// Asynchronous-SRAM-style external bus master: one access at a time through
// SETUP/STROBE/HOLD/TURN phases, with every bus pin driven straight from a flop.
module ext_bus_master #(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 2,
    parameter int unsigned TURN_CYC   = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WR,
    input  logic [13:0] ADDR_IN,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        ACK,
    output logic        BUSY,
    output logic [13:0] Addr,
    inout  wire  [15:0] Data,
    output logic        CSn,
    output logic        WEn,
    output logic        OEn
);

    localparam int unsigned AW = 14;
    localparam int unsigned DW = 16;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, TURN} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            wr_q, wr_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            ack_q, ack_d;
    logic            busy_q, busy_d;
    logic            csn_q, csn_d;
    logic            wen_q, wen_d;
    logic            oen_q, oen_d;
    logic            doe_q, doe_d;
    logic            cnt_last;
    logic            bus_active;

    // Phase sequencing; counter is loaded with (phase length - 1) on entry.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        ack_d    = 1'b0;
        cnt_last = (cnt_q == '0);

        case (state_q)
            IDLE: begin
                if (REQ) begin
                    state_d = SETUP;
                    cnt_d   = CW'(SETUP_CYC - 1);
                    wr_d    = WR;
                    addr_d  = ADDR_IN;
                    wdata_d = WDATA;
                end
            end
            SETUP: begin
                if (cnt_last) begin
                    state_d = STROBE;
                    cnt_d   = CW'(STROBE_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            STROBE: begin
                if (cnt_last) begin
                    state_d = HOLD;
                    cnt_d   = CW'(HOLD_CYC - 1);
                    if (!wr_q) begin
                        rdata_d = Data;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_last) begin
                    state_d = TURN;
                    cnt_d   = CW'(TURN_CYC - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            TURN: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Bus pins are decoded from the next state so they can be registered.
        bus_active = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        csn_d      = !bus_active;
        wen_d      = !((state_d == STROBE) && wr_d);
        oen_d      = !((state_d == STROBE) && !wr_d);
        doe_d      = bus_active && wr_d;
        busy_d     = (state_d != IDLE) || ack_d;
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            csn_q   <= 1'b1;
            wen_q   <= 1'b1;
            oen_q   <= 1'b1;
            doe_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            csn_q   <= csn_d;
            wen_q   <= wen_d;
            oen_q   <= oen_d;
            doe_q   <= doe_d;
        end
    end

    assign Data  = doe_q ? wdata_q : 'z;
    assign Addr  = addr_q;
    assign CSn   = csn_q;
    assign WEn   = wen_q;
    assign OEn   = oen_q;
    assign RDATA = rdata_q;
    assign ACK   = ack_q;
    assign BUSY  = busy_q;

endmodule

// File: tb/tb_ext_bus_master.sv
// Directed bench for ext_bus_master: default timing instance plus an
// all-ones timing instance, each compared cycle by cycle against fixed traces.
module tb_ext_bus_master;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, req1, wr;
    logic [13:0] addr_in;
    logic [15:0] wdata;
    logic [15:0] bus_val;

    logic [15:0] rdata, rdata1;
    logic        ack, busy, csn, wen, oen;
    logic        ack1, busy1, csn1, wen1, oen1;
    logic [13:0] addr, addr1;
    wire  [15:0] data_bus;
    wire  [15:0] data_bus1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Memory model: drives read data only while the DUT asserts OEn.
    assign data_bus = (!oen) ? bus_val : 16'hzzzz;

    ext_bus_master dut (
        .CLK(clk), .RESET(rst_n), .REQ(req), .WR(wr), .ADDR_IN(addr_in),
        .WDATA(wdata), .RDATA(rdata), .ACK(ack), .BUSY(busy), .Addr(addr),
        .Data(data_bus), .CSn(csn), .WEn(wen), .OEn(oen)
    );

    ext_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1), .TURN_CYC(1)) dut1 (
        .CLK(clk), .RESET(rst_n), .REQ(req1), .WR(wr), .ADDR_IN(addr_in),
        .WDATA(wdata), .RDATA(rdata1), .ACK(ack1), .BUSY(busy1), .Addr(addr1),
        .Data(data_bus1), .CSn(csn1), .WEn(wen1), .OEn(oen1)
    );

    task automatic run_access(input logic w, input logic [13:0] a, input logic [15:0] d,
                              input logic [15:0] cmp,
                              output logic [14:1] t_csn, output logic [14:1] t_wen,
                              output logic [14:1] t_oen, output logic [14:1] t_ack,
                              output logic [14:1] t_busy, output logic [14:1] t_dat,
                              output logic [13:0] a1, output logic [15:0] rd6,
                              output logic [15:0] rd10);
        @(negedge clk);
        req = 1'b1; wr = w; addr_in = a; wdata = d;
        for (int c = 1; c <= 14; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            t_csn[c]  = csn;
            t_wen[c]  = wen;
            t_oen[c]  = oen;
            t_ack[c]  = ack;
            t_busy[c] = busy;
            t_dat[c]  = (data_bus === cmp);
            if (c == 1)  a1   = addr;
            if (c == 6)  rd6  = rdata;
            if (c == 10) rd10 = rdata;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; req1 = 1'b0; wr = 1'b0;
        addr_in = '0; wdata = '0; bus_val = 16'h1234;
        #12;
        tests++;
        if ({csn, wen, oen, ack, busy} !== 5'b11100) begin
            fails++; $display("FAIL reset_ctrl: got %b expected 11100", {csn, wen, oen, ack, busy});
        end
        tests++;
        if ({addr, rdata} !== 30'h0) begin
            fails++; $display("FAIL reset_addr_rdata: got %h/%h expected 0/0", addr, rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); @(negedge clk);
        tests++;
        if ({csn, ack, busy, csn1, ack1, busy1} !== 6'b100100) begin
            fails++; $display("FAIL idle_after_reset: got %b expected 100100", {csn, ack, busy, csn1, ack1, busy1});
        end
    endtask

    task automatic test_write;
        logic [14:1] c_, w_, o_, k_, b_, d_;
        logic [13:0] a1; logic [15:0] r6, r10;
        run_access(1'b1, 14'h0010, 16'hA5A5, 16'hA5A5, c_, w_, o_, k_, b_, d_, a1, r6, r10);
        tests++; if (c_ !== 14'h3F00) begin fails++; $display("FAIL wr_csn: got %h expected 3f00", c_); end
        tests++; if (w_ !== 14'h3FC3) begin fails++; $display("FAIL wr_wen: got %h expected 3fc3", w_); end
        tests++; if (o_ !== 14'h3FFF) begin fails++; $display("FAIL wr_oen: got %h expected 3fff", o_); end
        tests++; if (k_ !== 14'h0200) begin fails++; $display("FAIL wr_ack: got %h expected 0200", k_); end
        tests++; if (b_ !== 14'h03FF) begin fails++; $display("FAIL wr_busy: got %h expected 03ff", b_); end
        tests++; if (d_ !== 14'h00FF) begin fails++; $display("FAIL wr_data: got %h expected 00ff", d_); end
        tests++; if (a1 !== 14'h0010) begin fails++; $display("FAIL wr_addr: got %h expected 0010", a1); end
        tests++; if (r10 !== 16'h0000) begin fails++; $display("FAIL wr_rdata: got %h expected 0000", r10); end
    endtask

    task automatic test_read;
        logic [14:1] c_, w_, o_, k_, b_, d_;
        logic [13:0] a1; logic [15:0] r6, r10;
        bus_val = 16'h1234;
        run_access(1'b0, 14'h0020, 16'hFFFF, 16'h1234, c_, w_, o_, k_, b_, d_, a1, r6, r10);
        tests++; if (c_ !== 14'h3F00) begin fails++; $display("FAIL rd_csn: got %h expected 3f00", c_); end
        tests++; if (w_ !== 14'h3FFF) begin fails++; $display("FAIL rd_wen: got %h expected 3fff", w_); end
        tests++; if (o_ !== 14'h3FC3) begin fails++; $display("FAIL rd_oen: got %h expected 3fc3", o_); end
        tests++; if (k_ !== 14'h0200) begin fails++; $display("FAIL rd_ack: got %h expected 0200", k_); end
        tests++; if (d_ !== 14'h003C) begin fails++; $display("FAIL rd_bus: got %h expected 003c", d_); end
        tests++; if (a1 !== 14'h0020) begin fails++; $display("FAIL rd_addr: got %h expected 0020", a1); end
        tests++; if (r6 !== 16'h0000) begin fails++; $display("FAIL rd_rdata_early: got %h expected 0000", r6); end
        tests++; if (r10 !== 16'h1234) begin fails++; $display("FAIL rd_rdata: got %h expected 1234", r10); end
    endtask

    task automatic test_write_keeps_rdata;
        logic [14:1] c_, w_, o_, k_, b_, d_;
        logic [13:0] a1; logic [15:0] r6, r10;
        run_access(1'b1, 14'h0030, 16'h5A5A, 16'h5A5A, c_, w_, o_, k_, b_, d_, a1, r6, r10);
        tests++; if (r10 !== 16'h1234) begin fails++; $display("FAIL wr_keeps_rdata: got %h expected 1234", r10); end
        tests++; if (d_ !== 14'h00FF) begin fails++; $display("FAIL wr2_data: got %h expected 00ff", d_); end
    endtask

    task automatic test_back_to_back;
        logic [24:1] c_, w_, o_, k_;
        logic [15:0] r20;
        bus_val = 16'hCAFE;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr_in = 14'h0040; wdata = 16'h0F0F;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            c_[c] = csn; w_[c] = wen; o_[c] = oen; k_[c] = ack;
            if (c == 20) r20 = rdata;
            if (c == 8) begin req = 1'b1; wr = 1'b0; addr_in = 14'h0041; end
            if (c == 11) req = 1'b0;
        end
        tests++; if (c_ !== 24'hFC0300) begin fails++; $display("FAIL b2b_csn: got %h expected fc0300", c_); end
        tests++; if (k_ !== 24'h080200) begin fails++; $display("FAIL b2b_ack: got %h expected 080200", k_); end
        tests++; if (w_ !== 24'hFFFFC3) begin fails++; $display("FAIL b2b_wen: got %h expected ffffc3", w_); end
        tests++; if (o_ !== 24'hFF0FFF) begin fails++; $display("FAIL b2b_oen: got %h expected ff0fff", o_); end
        tests++; if ((~w_ & ~o_) !== 24'h0) begin fails++; $display("FAIL b2b_both_low: got %h expected 000000", ~w_ & ~o_); end
        tests++; if (r20 !== 16'hCAFE) begin fails++; $display("FAIL b2b_rdata: got %h expected cafe", r20); end
    endtask

    task automatic test_ignore_busy;
        logic [24:1] c_, k_, b_;
        @(negedge clk);
        req = 1'b1; wr = 1'b1; addr_in = 14'h0050; wdata = 16'h1111;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
            c_[c] = csn; k_[c] = ack; b_[c] = busy;
            if (c == 3 || c == 6) req = 1'b1;
            if (c == 4 || c == 7) req = 1'b0;
        end
        tests++; if (k_ !== 24'h000200) begin fails++; $display("FAIL ign_ack: got %h expected 000200", k_); end
        tests++; if (c_ !== 24'hFFFF00) begin fails++; $display("FAIL ign_csn: got %h expected ffff00", c_); end
        tests++; if (b_ !== 24'h0003FF) begin fails++; $display("FAIL ign_busy: got %h expected 0003ff", b_); end
    endtask

    task automatic test_reset_mid;
        logic [14:1] c_, w_, o_, k_, b_, d_;
        logic [13:0] a1; logic [15:0] r6, r10;
        int acks;
        bus_val = 16'hBEEF;
        @(negedge clk);
        req = 1'b1; wr = 1'b0; addr_in = 14'h0060;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            if (c == 1) req = 1'b0;
        end
        tests++; if (oen !== 1'b0) begin fails++; $display("FAIL rst_pre_oen: got %b expected 0", oen); end
        rst_n = 1'b0;
        #1;
        tests++;
        if ({csn, wen, oen, ack, busy} !== 5'b11100) begin
            fails++; $display("FAIL rst_mid_ctrl: got %b expected 11100", {csn, wen, oen, ack, busy});
        end
        tests++; if (data_bus === 16'hBEEF) begin fails++; $display("FAIL rst_mid_bus: got %h expected released", data_bus); end
        tests++; if ({addr, rdata} !== 30'h0) begin fails++; $display("FAIL rst_mid_regs: got %h/%h expected 0/0", addr, rdata); end
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        tests++; if (acks !== 0) begin fails++; $display("FAIL rst_no_ack: got %0d expected 0", acks); end
        tests++; if (rdata !== 16'h0000) begin fails++; $display("FAIL rst_rdata: got %h expected 0000", rdata); end
        run_access(1'b1, 14'h0070, 16'h7777, 16'h7777, c_, w_, o_, k_, b_, d_, a1, r6, r10);
        tests++; if (c_ !== 14'h3F00) begin fails++; $display("FAIL post_rst_csn: got %h expected 3f00", c_); end
        tests++; if (k_ !== 14'h0200) begin fails++; $display("FAIL post_rst_ack: got %h expected 0200", k_); end
        tests++; if (a1 !== 14'h0070) begin fails++; $display("FAIL post_rst_addr: got %h expected 0070", a1); end
    endtask

    task automatic test_min_params;
        logic [8:1] c_, w_, k_, d_;
        @(negedge clk);
        req1 = 1'b1; wr = 1'b1; addr_in = 14'h0001; wdata = 16'h2222;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (c == 1) req1 = 1'b0;
            c_[c] = csn1; w_[c] = wen1; k_[c] = ack1;
            d_[c] = (data_bus1 === 16'h2222);
        end
        tests++; if (c_ !== 8'hF8) begin fails++; $display("FAIL min_csn: got %h expected f8", c_); end
        tests++; if (w_ !== 8'hFD) begin fails++; $display("FAIL min_wen: got %h expected fd", w_); end
        tests++; if (k_ !== 8'h10) begin fails++; $display("FAIL min_ack: got %h expected 10", k_); end
        tests++; if (d_ !== 8'h07) begin fails++; $display("FAIL min_data: got %h expected 07", d_); end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read;
        test_write_keeps_rdata;
        test_back_to_back;
        test_ignore_busy;
        test_reset_mid;
        test_min_params;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ext_bus_master.md
EXT_BUS_MASTER -- requirements
Module: ext_bus_master

Interface
REQ-001 Parameter: SETUP_CYC, default 2, CLK cycles from CSn falling to strobe (WEn/OEn) falling; legal 1..15.
REQ-002 Parameter: STROBE_CYC, default 4, CLK cycles WEn or OEn held low; legal 1..15.
REQ-003 Parameter: HOLD_CYC, default 2, CLK cycles from strobe rising to CSn rising; legal 1..15.
REQ-004 Parameter: TURN_CYC, default 1, CLK cycles CSn held high after every access before the next may start; legal 1..15.
REQ-005 CLK  input  1  single clock for all logic, 200 MHz.
REQ-006 RESET  input  1  asynchronous, active-low reset.
REQ-007 REQ  input  1  access request, sampled on CLK rising edge while BUSY=0.
REQ-008 WR  input  1  access type sampled with REQ: 1=write, 0=read.
REQ-009 ADDR_IN  input  14  access address, sampled with REQ.
REQ-010 WDATA  input  16  write data, sampled with REQ.
REQ-011 RDATA  output  16  data captured by the most recent completed read.
REQ-012 ACK  output  1  one-cycle completion pulse.
REQ-013 BUSY  output  1  high from the cycle after REQ acceptance until the cycle ACK is asserted, inclusive.
REQ-014 Addr  output  14  external bus address.
REQ-015 Data  inout  16  external bus data; driven only during write accesses, high-impedance otherwise.
REQ-016 CSn, WEn, OEn  output  1 each  active-low chip select, write strobe, output enable.

Function
REQ-017 All bus outputs (Addr, CSn, WEn, OEn, Data output-enable and value) SHALL come directly from flip-flops; no combinational decode onto the bus.
REQ-018 FSM states: IDLE, SETUP, STROBE, HOLD, TURN; one 4-bit down-counter, loaded with (phase length - 1) on each state entry.
REQ-019 IDLE: REQ=1 at edge k latches WR/ADDR_IN/WDATA and enters SETUP; from cycle k+1, CSn=0 and Addr=latched address.
REQ-020 SETUP lasts SETUP_CYC cycles with WEn=OEn=1, then STROBE.
REQ-021 STROBE lasts STROBE_CYC cycles with WEn=0 (write) or OEn=0 (read); never both low.
REQ-022 HOLD lasts HOLD_CYC cycles with CSn=0 and WEn=OEn=1, then TURN.
REQ-023 TURN lasts TURN_CYC cycles with CSn=1, then IDLE; ACK=1 for the single TURN-to-IDLE transition cycle (first IDLE cycle).
REQ-024 Addr held stable from SETUP entry through the last HOLD cycle; holds last value during TURN/IDLE.
REQ-025 Write: Data driven with latched WDATA throughout SETUP, STROBE and HOLD; released to Z on TURN entry.
REQ-026 Read: Data never driven; RDATA loaded from Data on the clock edge ending the last STROBE cycle; RDATA unchanged by writes.
REQ-027 REQ while BUSY=1 SHALL be ignored (not queued); REQ in the ACK cycle SHALL be accepted (back-to-back).
REQ-028 Latency, REQ edge to ACK: SETUP_CYC+STROBE_CYC+HOLD_CYC+TURN_CYC+1 cycles (defaults: 10).

Reset
REQ-029 RESET=0 SHALL immediately (asynchronously) force IDLE, CSn=WEn=OEn=1, Data high-impedance, Addr=0, RDATA=0, ACK=0, BUSY=0, counter=0.
REQ-030 Reset mid-access SHALL abort with no ACK and no RDATA update; first REQ after release SHALL start a clean access.

Verification
REQ-031 Defaults, write Addr 0x0010 data 0xA5A5 -> CSn low cycles 1-8, WEn low cycles 3-6, OEn high throughout, Data=0xA5A5 cycles 1-8 then Z, ACK at cycle 10.
REQ-032 Defaults, read Addr 0x0020, bus model drives 0x1234 while OEn=0 -> OEn low cycles 3-6, Data never driven by DUT, RDATA=0x1234 with ACK at cycle 10.
REQ-033 Back-to-back: write then REQ held high in ACK cycle for read -> second CSn falls exactly TURN_CYC+1 cycles after first CSn rises; no cycle with WEn and OEn both low.
REQ-034 REQ pulsed at cycles 3 and 6 of an active access -> ignored; exactly one ACK.
REQ-035 RESET low during STROBE of a read -> CSn/OEn high and Data Z within the same cycle, RDATA=0, no ACK.
REQ-036 SETUP_CYC=STROBE_CYC=HOLD_CYC=TURN_CYC=1, write -> CSn low 3 cycles, WEn low 1 cycle, ACK at cycle 5.
